// File: rtl/stdp_lif_multi.sv
// ============================================================================
// Module   : stdp_lif_multi
// Brief    : LIF neuron with refractory period and N_IN pair-based STDP synapses
// Revision : 1.0
// ============================================================================
`default_nettype none

module stdp_lif_multi #(
    parameter int N_IN       = 4,
    parameter int W_W        = 8,
    parameter int V_W        = 8,
    parameter int TRACE_W    = 4,
    parameter int THRESH     = 200,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRACT    = 2,
    parameter int W_INIT     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_IN-1:0]          in_spike,
    input  logic                     learn_en,
    input  logic                     w_load,
    input  logic [$clog2(N_IN)-1:0]  w_load_idx,
    input  logic [W_W-1:0]           w_load_data,
    input  logic [$clog2(N_IN)-1:0]  rd_idx,
    output logic [W_W-1:0]           rd_weight,
    output logic                     spike,
    output logic [V_W-1:0]           state
);

    localparam int c_IDX_W = $clog2(N_IN);
    localparam int c_SUM_W = ((V_W > W_W) ? V_W : W_W) + c_IDX_W + 1;
    localparam int c_D_W   = ((W_W > TRACE_W) ? W_W : TRACE_W) + 2;
    localparam int c_R_W   = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

    localparam logic [V_W-1:0]     c_V_MAX  = '1;
    localparam logic [W_W-1:0]     c_W_MAX  = '1;
    localparam logic [TRACE_W-1:0] c_T_MAX  = '1;
    localparam logic [V_W-1:0]     c_THRESH = V_W'(THRESH);

    logic [V_W-1:0]                   r_v;
    logic [c_R_W-1:0]                 r_refr;
    logic                             r_spike;
    logic [TRACE_W-1:0]               r_post;
    logic [N_IN-1:0][TRACE_W-1:0]     r_pre;
    logic [N_IN-1:0][W_W-1:0]         r_weight;

    logic [V_W-1:0]                   w_leak;
    logic [c_SUM_W-1:0]               w_isum;
    logic [c_SUM_W-1:0]               w_vfull;
    logic [V_W-1:0]                   w_vint;
    logic                             w_fire;
    logic [TRACE_W-1:0]               w_post_next;
    logic [N_IN-1:0][TRACE_W-1:0]     w_pre_next;
    logic [N_IN-1:0][W_W-1:0]         w_w_next;

    // Integration always uses the weights held before this edge's learning.
    always_comb begin
        w_isum = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (in_spike[i]) begin
                w_isum = w_isum + c_SUM_W'(r_weight[i]);
            end
        end
    end

    assign w_leak  = r_v >> LEAK_SHIFT;
    assign w_vfull = c_SUM_W'(r_v) - c_SUM_W'(w_leak) + w_isum;
    assign w_vint  = (w_vfull > c_SUM_W'(c_V_MAX)) ? c_V_MAX : w_vfull[V_W-1:0];
    assign w_fire  = (r_refr == '0) && (w_vint >= c_THRESH);

    assign w_post_next = w_fire ? c_T_MAX :
                         ((r_post == '0) ? '0 : r_post - TRACE_W'(1));

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_syn
            logic [TRACE_W-1:0]      w_ltp;
            logic [TRACE_W-1:0]      w_ltd;
            logic signed [c_D_W-1:0] w_sum;
            logic [W_W-1:0]          w_learned;

            assign w_ltp = w_fire ? r_pre[gi] : '0;
            assign w_ltd = in_spike[gi] ? r_post : '0;
            assign w_sum = $signed(c_D_W'(r_weight[gi])) + $signed(c_D_W'(w_ltp))
                         - $signed(c_D_W'(w_ltd));

            assign w_learned = w_sum[c_D_W-1] ? '0 :
                               (w_sum > $signed(c_D_W'(c_W_MAX))) ? c_W_MAX :
                               w_sum[W_W-1:0];

            // A load on this index wins over learning; other channels keep learning.
            assign w_w_next[gi] = (w_load && (w_load_idx == c_IDX_W'(gi))) ? w_load_data :
                                  learn_en ? w_learned : r_weight[gi];

            assign w_pre_next[gi] = in_spike[gi] ? c_T_MAX :
                                    ((r_pre[gi] == '0) ? '0 : r_pre[gi] - TRACE_W'(1));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v      <= '0;
            r_refr   <= '0;
            r_spike  <= 1'b0;
            r_post   <= '0;
            r_pre    <= '0;
            for (int i = 0; i < N_IN; i++) begin
                r_weight[i] <= W_W'(W_INIT);
            end
        end else begin
            r_post   <= w_post_next;
            r_pre    <= w_pre_next;
            r_weight <= w_w_next;
            if (r_refr != '0) begin
                r_v     <= '0;
                r_refr  <= r_refr - c_R_W'(1);
                r_spike <= 1'b0;
            end else if (w_fire) begin
                r_v     <= '0;
                r_refr  <= c_R_W'(REFRACT);
                r_spike <= 1'b1;
            end else begin
                r_v     <= w_vint;
                r_spike <= 1'b0;
            end
        end
    end

    assign rd_weight = (32'(rd_idx) < 32'(N_IN)) ? r_weight[rd_idx] : '0;
    assign spike     = r_spike;
    assign state     = r_v;

endmodule

`default_nettype wire

// File: tb/tb_stdp_lif_multi.sv
// ============================================================================
// Module   : tb_stdp_lif_multi
// Brief    : Directed and random checks of stdp_lif_multi against a reference model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stdp_lif_multi;

    localparam int N_IN = 4;
    localparam int W_MAX = 255;
    localparam int V_MAX = 255;
    localparam int T_MAX = 15;
    localparam int THRESH = 200;
    localparam int LEAK_SHIFT = 3;
    localparam int REFRACT = 2;
    localparam int W_INIT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_spike = '0;
    logic       learn_en = 1'b0;
    logic       w_load = 1'b0;
    logic [1:0] w_load_idx = '0;
    logic [7:0] w_load_data = '0;
    logic [1:0] rd_idx = '0;
    logic [7:0] rd_weight;
    logic       spike;
    logic [7:0] state;

    int n_checks = 0;
    int n_fail = 0;

    int m_v, m_refr, m_spike, m_post;
    int m_pre [N_IN];
    int m_w   [N_IN];

    stdp_lif_multi dut (
        .clk(clk), .rst(rst), .in_spike(in_spike), .learn_en(learn_en),
        .w_load(w_load), .w_load_idx(w_load_idx), .w_load_data(w_load_data),
        .rd_idx(rd_idx), .rd_weight(rd_weight), .spike(spike), .state(state)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference neuron: plain integer arithmetic straight from the behavioural rules.
    task automatic model_step();
        int leak, isum, vint, nw;
        bit fire;
        if (rst) begin
            m_v = 0; m_refr = 0; m_spike = 0; m_post = 0;
            for (int i = 0; i < N_IN; i++) begin
                m_pre[i] = 0;
                m_w[i] = W_INIT;
            end
            return;
        end
        leak = m_v >> LEAK_SHIFT;
        isum = 0;
        for (int i = 0; i < N_IN; i++) if (in_spike[i]) isum += m_w[i];
        vint = m_v - leak + isum;
        if (vint > V_MAX) vint = V_MAX;
        fire = (m_refr == 0) && (vint >= THRESH);
        for (int i = 0; i < N_IN; i++) begin
            nw = m_w[i];
            if (learn_en) begin
                nw = nw + (fire ? m_pre[i] : 0) - (in_spike[i] ? m_post : 0);
                if (nw < 0) nw = 0;
                if (nw > W_MAX) nw = W_MAX;
            end
            if (w_load && int'(w_load_idx) == i) nw = int'(w_load_data);
            m_w[i] = nw;
            m_pre[i] = in_spike[i] ? T_MAX : ((m_pre[i] > 0) ? m_pre[i] - 1 : 0);
        end
        m_post = fire ? T_MAX : ((m_post > 0) ? m_post - 1 : 0);
        if (m_refr != 0) begin
            m_v = 0; m_refr--; m_spike = 0;
        end else if (fire) begin
            m_v = 0; m_spike = 1; m_refr = REFRACT;
        end else begin
            m_v = vint; m_spike = 0;
        end
    endtask

    task automatic compare_all();
        chk("spike", 32'(spike), m_spike);
        chk("state", 32'(state), m_v);
        for (int i = 0; i < N_IN; i++) begin
            rd_idx = 2'(i);
            #1;
            chk("rd_weight", 32'(rd_weight), m_w[i]);
        end
    endtask

    task automatic cycle(input logic r, input logic [3:0] ins, input logic le,
                         input logic ld, input logic [1:0] li, input logic [7:0] ldd);
        rst = r; in_spike = ins; learn_en = le;
        w_load = ld; w_load_idx = li; w_load_data = ldd;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic lit_w(input int idx, input int exp);
        rd_idx = 2'(idx);
        #1;
        chk("lit_weight", 32'(rd_weight), exp);
    endtask

    initial begin
        // Reset with all inputs spiking
        cycle(1, 4'hF, 0, 0, 0, 0);
        cycle(1, 4'hF, 0, 0, 0, 0);
        chk("lit_rst_state", 32'(state), 0);
        chk("lit_rst_spike", 32'(spike), 0);
        for (int i = 0; i < N_IN; i++) lit_w(i, 16);

        // Leak and integration
        cycle(0, 4'h0, 0, 1, 0, 8'd100);
        cycle(0, 4'h1, 0, 0, 0, 0);
        chk("lit_leak0", 32'(state), 100);
        cycle(0, 4'h0, 0, 0, 0, 0);
        chk("lit_leak1", 32'(state), 88);
        cycle(0, 4'h0, 0, 0, 0, 0);
        chk("lit_leak2", 32'(state), 77);
        cycle(0, 4'h0, 0, 0, 0, 0);
        chk("lit_leak3", 32'(state), 68);
        cycle(1, 4'h0, 0, 0, 0, 0);

        // Fire and refractory
        cycle(0, 4'h0, 0, 1, 0, 8'd120);
        cycle(0, 4'h0, 0, 1, 1, 8'd120);
        cycle(0, 4'h3, 0, 0, 0, 0);
        chk("lit_fire_spike", 32'(spike), 1);
        chk("lit_fire_state", 32'(state), 0);
        cycle(0, 4'hF, 0, 0, 0, 0);
        chk("lit_refr1_spike", 32'(spike), 0);
        chk("lit_refr1_state", 32'(state), 0);
        cycle(0, 4'hF, 0, 0, 0, 0);
        chk("lit_refr2_spike", 32'(spike), 0);
        chk("lit_refr2_state", 32'(state), 0);
        cycle(0, 4'h1, 0, 0, 0, 0);
        chk("lit_after_refr", 32'(state), 120);
        cycle(1, 4'h0, 0, 0, 0, 0);

        // LTP then LTD during refractory
        cycle(0, 4'h0, 1, 1, 0, 8'd120);
        cycle(0, 4'h0, 1, 1, 1, 8'd120);
        cycle(0, 4'h1, 1, 0, 0, 0);
        chk("lit_ltp_state", 32'(state), 120);
        cycle(0, 4'h2, 1, 0, 0, 0);
        chk("lit_ltp_spike", 32'(spike), 1);
        lit_w(0, 135);
        lit_w(1, 120);
        cycle(0, 4'h4, 1, 0, 0, 0);
        lit_w(2, 1);
        cycle(0, 4'h4, 1, 0, 0, 0);
        lit_w(2, 0);
        cycle(1, 4'h0, 0, 0, 0, 0);

        // Weight saturation at W_MAX
        cycle(0, 4'h0, 1, 1, 3, 8'd250);
        cycle(0, 4'h0, 1, 1, 0, 8'd210);
        cycle(0, 4'h8, 1, 0, 0, 0);
        chk("lit_sat_fire1", 32'(spike), 1);
        cycle(0, 4'h0, 1, 0, 0, 0);
        cycle(0, 4'h0, 1, 0, 0, 0);
        cycle(0, 4'h1, 1, 0, 0, 0);
        chk("lit_sat_fire2", 32'(spike), 1);
        lit_w(3, 255);
        lit_w(0, 197);
        cycle(1, 4'h0, 0, 0, 0, 0);

        // Load priority over learning on the same edge
        cycle(0, 4'h0, 1, 1, 3, 8'd250);
        cycle(0, 4'h0, 1, 1, 0, 8'd210);
        cycle(0, 4'h8, 1, 0, 0, 0);
        cycle(0, 4'h0, 1, 0, 0, 0);
        cycle(0, 4'h0, 1, 0, 0, 0);
        cycle(0, 4'h1, 1, 1, 3, 8'd7);
        lit_w(3, 7);
        lit_w(0, 197);
        lit_w(1, 16);
        cycle(1, 4'h0, 0, 0, 0, 0);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] ins;
            for (int b = 0; b < 4; b++) ins[b] = ($urandom_range(0, 3) == 0);
            cycle(($urandom_range(0, 299) == 0),
                  ins,
                  ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 11) == 0),
                  2'($urandom_range(0, 3)),
                  8'($urandom_range(0, 255)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
